addsub_result_stage: RTL and testbench
======================================

ADDSUB_RESULT_STAGE -- requirements
Module: addsub_result_stage

Interface
REQ-001 Parameter CNT_W, default 8, width of the saturating overflow-event counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream 16-bit adder/subtractor result is valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_sum  input  16  sum output of the 16-bit adder/subtractor.
REQ-007 in_cout  input  1  carry-out of the adder/subtractor MSB slice.
REQ-008 in_mode  input  1  operation that produced in_sum (0 add, 1 subtract).
REQ-009 in_a_msb  input  1  bit 15 of operand a.
REQ-010 in_b_msb  input  1  bit 15 of operand b, before the subtract inversion.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_sum  output  16  registered result.
REQ-014 out_carry  output  1  carry for add; borrow for subtract.
REQ-015 out_zero  output  1  out_sum == 0.
REQ-016 out_neg  output  1  out_sum[15].
REQ-017 out_of  output  1  two's-complement signed overflow.
REQ-018 clr_count  input  1  synchronous clear of ovf_count.
REQ-019 ovf_count  output  CNT_W  number of accepted results with overflow, saturating.

Function
REQ-020 The block SHALL compute flags combinationally from the inputs at acceptance and store them with the sum as one entry.
REQ-021 Carry: add -> in_cout; subtract -> ~in_cout (borrow).
REQ-022 Overflow: add -> (a_msb==b_msb) && (in_sum[15]!=a_msb); subtract -> (a_msb!=b_msb) && (in_sum[15]!=a_msb).
REQ-023 Storage SHALL be a 2-entry FIFO with an occupancy count of 0..2.
REQ-024 Push happens on in_valid && in_ready; pop happens on out_valid && out_ready.
REQ-025 in_ready SHALL equal (count < 2), driven from registered state only and independent of out_ready.
REQ-026 out_valid SHALL equal (count != 0); out_* fields SHALL show the head entry.
REQ-027 Latency: an entry pushed in cycle N SHALL be visible on the outputs in cycle N+1 if the FIFO was empty.
REQ-028 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-029 Ordering SHALL be strictly FIFO; there is no loss or duplication.
REQ-030 The head entry and its flags SHALL stay stable while out_valid && !out_ready.
REQ-031 With count = 2 and a pop, in_ready is still 0 that cycle, so no push occurs.
REQ-032 ovf_count SHALL increment on each push whose overflow flag is 1, and SHALL hold at 2^CNT_W-1.
REQ-033 clr_count SHALL take priority: clear and overflow push in the same cycle gives ovf_count = 0.
REQ-034 Inputs SHALL be ignored when in_valid = 0, and when in_valid = 1 while in_ready = 0.

Reset
REQ-035 While rst is high at a clock edge, the FIFO SHALL empty: count 0, out_valid 0, in_ready 1.
REQ-036 On the same reset, out_sum, out_carry, out_zero, out_neg, out_of and ovf_count SHALL all be 0.
REQ-037 Reset SHALL override a simultaneous push, pop or clr_count.
REQ-038 Entries held at reset SHALL be discarded.

Verification
REQ-039 Add overflow: sum 0x8000, cout 0, mode 0, a_msb 0, b_msb 0 -> next cycle out_sum 0x8000, of 1, neg 1, zero 0, carry 0; ovf_count 1.
REQ-040 Subtract equal operands: sum 0x0000, cout 1, mode 1, a_msb 0, b_msb 0 -> zero 1, carry 0, of 0, neg 0.
REQ-041 Subtract borrow and overflow:
- 3 - 5: sum 0xFFFE, cout 0, mode 1 -> carry 1, neg 1, of 0.
- 0x8000 - 0x0001: sum 0x7FFF, cout 1, a_msb 1, b_msb 0 -> of 1.
REQ-042 Backpressure: out_ready 0, three consecutive valid beats -> in_ready 0 after two accepted, third held; then out_ready 1 -> outputs in push order, no loss.
REQ-043 Saturation and clear:
- 300 overflow pushes with CNT_W 8 -> ovf_count 255.
- clr_count together with an overflow push -> ovf_count 0.
REQ-044 Reset mid-operation: count 2, assert rst one cycle -> next cycle out_valid 0, in_ready 1, ovf_count 0, all out fields 0.

Source files
------------

// File: rtl/addsub_result_stage.sv
// Result stage for a 16-bit adder/subtractor: derives carry/borrow, zero,
// sign and signed-overflow flags and buffers them in a 2-entry FIFO.
module addsub_result_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_sum,
    input  logic             in_cout,
    input  logic             in_mode,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_of,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        zero;
        logic        neg;
        logic        of;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t     mem [2];
    entry_t     in_ent;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Flags are resolved at acceptance so the stored entry is self-contained.
    always_comb begin
        in_ent      = '0;
        in_ent.sum  = in_sum;
        in_ent.zero = (in_sum == 16'h0000);
        in_ent.neg  = in_sum[15];
        unique case (1'b1)
            in_mode: begin
                in_ent.carry = ~in_cout;
                in_ent.of    = (in_a_msb != in_b_msb) &&
                               (in_sum[15] != in_a_msb);
            end
            !in_mode: begin
                in_ent.carry = in_cout;
                in_ent.of    = (in_a_msb == in_b_msb) &&
                               (in_sum[15] != in_a_msb);
            end
        endcase
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_sum   = head.sum;
    assign out_carry = head.carry;
    assign out_zero  = head.zero;
    assign out_neg   = head.neg;
    assign out_of    = head.of;

    // Clear wins over a same-cycle overflow push.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= '0;
        end else if (push && in_ent.of && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: directed vectors plus a randomized run
// checked against an arithmetic model with a queue for the FIFO.
module tb_addsub_result_stage;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        zero;
        logic        neg;
        logic        of;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic        in_mode = 1'b0;
    logic        in_a_msb = 1'b0;
    logic        in_b_msb = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        out_zero;
    logic        out_neg;
    logic        out_of;
    logic        clr_count = 1'b0;
    logic [7:0]  ovf_count;

    int tests = 0;
    int errors = 0;

    addsub_result_stage #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_mode(in_mode),
        .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_zero(out_zero),
        .out_neg(out_neg), .out_of(out_of),
        .clr_count(clr_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Expected entry from plain integer arithmetic on the operands.
    function automatic ent_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic m);
        ent_t e;
        int   r;
        if (m) begin
            e.sum   = a - b;
            e.carry = (a < b);
            r = int'($signed(a)) - int'($signed(b));
        end else begin
            e.sum   = a + b;
            e.carry = (32'(a) + 32'(b)) > 32'h0000_FFFF;
            r = int'($signed(a)) + int'($signed(b));
        end
        e.zero = (e.sum == 16'h0000);
        e.neg  = e.sum[15];
        e.of   = (r > 32767) || (r < -32768);
        return e;
    endfunction

    // Emulates the upstream adder/subtractor feeding the stage.
    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic m);
        logic [16:0] full;
        if (m) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   full = {1'b0, a} + {1'b0, b};
        in_valid = v;
        in_mode  = m;
        in_sum   = full[15:0];
        in_cout  = full[16];
        in_a_msb = a[15];
        in_b_msb = b[15];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 16'h0, 16'h0, 0);
        clr_count = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        clr_count = 1'b1;
        drive(1, 16'h4000, 16'h4000, 0);
        tick();
        tick();
        rst       = 1'b0;
        clr_count = 1'b0;
        drive(0, 16'h0, 16'h0, 0);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got v=%b r=%b want v=0 r=1",
                     out_valid, in_ready);
        end
        tests++;
        if ({out_sum, out_carry, out_zero, out_neg, out_of} !== 20'h0 ||
            ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_fields got sum=%h c=%b z=%b n=%b o=%b cnt=%0d want 0",
                     out_sum, out_carry, out_zero, out_neg, out_of, ovf_count);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [4] = '{16'h4000, 16'h1234, 16'h0003, 16'h8000};
        logic [15:0] vb [4] = '{16'h4000, 16'h1234, 16'h0005, 16'h0001};
        logic        vm [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        ent_t        ve [4];
        int          vc [4] = '{1, 1, 1, 2};
        ent_t        obs;
        ve[0] = '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        ve[1] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        ve[2] = '{16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        ve[3] = '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, va[i], vb[i], vm[i]);
            tick();
            drive(0, 16'h0, 16'h0, 0);
            @(negedge clk);
            obs = '{out_sum, out_carry, out_zero, out_neg, out_of};
            tests++;
            if (out_valid !== 1'b1 || obs !== ve[i]) begin
                errors++;
                $display("FAIL vec%0d got v=%b ent=%h want v=1 ent=%h",
                         i, out_valid, obs, ve[i]);
            end
            tests++;
            if (ovf_count !== 8'(vc[i])) begin
                errors++;
                $display("FAIL vec%0d_cnt got %0d want %0d",
                         i, ovf_count, vc[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic        exp_rdy [7] = '{1, 1, 0, 0, 0, 1, 1};
        logic [15:0] exp_sum [7] = '{16'h0, 16'h11, 16'h11, 16'h11,
                                     16'h11, 16'h22, 16'h33};
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(1, 16'h10, 16'h1, 0);
            if (c == 1) drive(1, 16'h20, 16'h2, 0);
            if (c == 2) drive(1, 16'h30, 16'h3, 0);
            if (c == 4) out_ready = 1'b1;
            if (c == 6) drive(0, 16'h0, 16'h0, 0);
            @(negedge clk);
            tests++;
            if (in_ready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL bp_ready c%0d got %b want %b",
                         c, in_ready, exp_rdy[c]);
            end
            if (c > 0) begin
                tests++;
                if (out_valid !== 1'b1 || out_sum !== exp_sum[c]) begin
                    errors++;
                    $display("FAIL bp_head c%0d got v=%b sum=%h want v=1 sum=%h",
                             c, out_valid, out_sum, exp_sum[c]);
                end
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        drive(1, 16'h4000, 16'h4000, 0);
        repeat (10) tick();
        @(negedge clk);
        tests++;
        if (ovf_count !== 8'd10) begin
            errors++;
            $display("FAIL sat_mid got %0d want 10", ovf_count);
        end
        tick();
        repeat (289) tick();
        drive(0, 16'h0, 16'h0, 0);
        @(negedge clk);
        tests++;
        if (ovf_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold got %0d want 255", ovf_count);
        end
    endtask

    task automatic test_clear();
        drive(1, 16'h4000, 16'h4000, 0);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        drive(0, 16'h0, 16'h0, 0);
        @(negedge clk);
        tests++;
        if (ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_prio got %0d want 0", ovf_count);
        end
        drive(1, 16'h8000, 16'h8000, 0);
        tick();
        drive(0, 16'h0, 16'h0, 0);
        @(negedge clk);
        tests++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL clr_resume got %0d want 1", ovf_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        drive(1, 16'h4000, 16'h4000, 0);
        tick();
        drive(1, 16'h0001, 16'h0002, 0);
        tick();
        drive(0, 16'h0, 16'h0, 0);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_full got r=%b v=%b cnt=%0d want r=0 v=1 cnt=1",
                     in_ready, out_valid, ovf_count);
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1, 16'h7FFF, 16'h0001, 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        drive(0, 16'h0, 16'h0, 0);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 8'd0 ||
            {out_sum, out_carry, out_zero, out_neg, out_of} !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b cnt=%0d sum=%h flags=%b%b%b%b",
                     out_valid, in_ready, ovf_count, out_sum,
                     out_carry, out_zero, out_neg, out_of);
        end
    endtask

    task automatic test_random();
        ent_t        q [$];
        ent_t        e;
        ent_t        obs;
        int          exp_ov = 0;
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        v;
        logic        pu;
        logic        po;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            m = 1'($urandom);
            v = ($urandom_range(0, 9) < 7);
            drive(v, a, b, m);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_count = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            tests++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_hs c%0d got v=%b r=%b want occupancy %0d",
                         c, out_valid, in_ready, q.size());
            end
            if (q.size() != 0) begin
                obs = '{out_sum, out_carry, out_zero, out_neg, out_of};
                tests++;
                if (obs !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_head c%0d got %h want %h", c, obs, q[0]);
                end
            end
            tests++;
            if (ovf_count !== 8'(exp_ov)) begin
                errors++;
                $display("FAIL rnd_cnt c%0d got %0d want %0d",
                         c, ovf_count, exp_ov);
            end
            e  = model(a, b, m);
            pu = v && (q.size() < 2);
            po = (q.size() != 0) && out_ready;
            if (po) void'(q.pop_front());
            if (pu) q.push_back(e);
            if (clr_count) exp_ov = 0;
            else if (pu && e.of && exp_ov < 255) exp_ov++;
            tick();
        end
        clr_count = 1'b0;
        drive(0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", tests, errors);
        $finish;
    end

endmodule
